pipe_exec_ctrl: RTL and testbench

Execution controller for the pipelined datapath: generates per-stage pipeline-register enables and bubble-insert (flush) strobes. Also adds the behaviour the plain free-running pipeline lacks: start/halt control, continuous or single-step mode, load-use stall insertion, branch flush, halt drain and a cycle counter. It sits beside `datapath_pipe`, driven by hazard and decode flags from the ID stage and by run/step commands from the debug side.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_exec_ctrl_sat_counter.sv | 23 ++
 rtl/pipe_exec_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_exec_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline execution controller: FSM states,
// pipeline-register indices and the run mode.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit positions inside the per-register enable/flush vectors
  localparam int ST_PC    = 0;
  localparam int ST_IFID  = 1;
  localparam int ST_IDEX  = 2;
  localparam int ST_EXMEM = 3;
  localparam int ST_MEMWB = 4;

  typedef enum logic {
    MODE_CONT = 1'b0,
    MODE_STEP = 1'b1
  } mode_t;

endpackage

// File: rtl/pipe_exec_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_exec_ctrl.sv
// Execution controller: per-register enables and bubble strobes for the
// pipelined datapath, with run/step control, load-use stall, branch flush
// and halt drain.
module pipe_exec_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES = 5,
  parameter int CBITS   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_mode,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_halt_id,
  input  logic               i_ld_use,
  input  logic               i_branch_taken,
  output logic [NSTAGES-1:0] o_stage_en,
  output logic [NSTAGES-1:0] o_flush,
  output logic               o_busy,
  output logic               o_done,
  output logic [1:0]         o_state,
  output logic [CBITS-1:0]   o_cycles
);

  localparam int DBITS = $clog2(NSTAGES);
  // Drain advances still owed after the halt is detected
  localparam logic [DBITS-1:0] DRAIN_LOAD = DBITS'(NSTAGES - 3);

  state_t           state_reg, state_next;
  logic [DBITS-1:0] drain_reg, drain_next;
  logic             adv;
  logic             start;

  assign adv = ((state_reg == RUN) || (state_reg == DRAIN)) &&
               ((i_mode == MODE_CONT) || i_step);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    o_stage_en = '0;
    o_flush    = '0;
    start      = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (i_run) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        if (adv) begin
          o_stage_en = '1;
          if (i_ld_use) begin
            // Hold PC and IF/ID, bubble into ID/EX
            o_stage_en[ST_PC]   = 1'b0;
            o_stage_en[ST_IFID] = 1'b0;
            o_flush[ST_IDEX]    = 1'b1;
          end else if (i_halt_id) begin
            o_stage_en[ST_PC] = 1'b0;
            o_flush[ST_IFID]  = 1'b1;
            drain_next        = DRAIN_LOAD;
            state_next        = DRAIN;
          end else if (i_branch_taken) begin
            o_flush[ST_IFID] = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (adv) begin
          o_stage_en        = '1;
          o_stage_en[ST_PC] = 1'b0;
          o_flush[ST_IFID]  = 1'b1;
          // The advance that consumes the last owed slot also finishes
          if (drain_reg <= DBITS'(1)) begin
            drain_next = '0;
            state_next = DONE;
          end else begin
            drain_next = drain_reg - DBITS'(1);
          end
        end
      end
      default: ;
    endcase
  end

  sat_counter #(
    .W (CBITS)
  ) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .inc   (adv),
    .count (o_cycles)
  );

  assign o_state = state_reg;
  assign o_busy  = (state_reg == RUN) || (state_reg == DRAIN);
  assign o_done  = (state_reg == DONE);

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// Directed plus randomized bench for pipe_exec_ctrl, checked every cycle
// against a behavioural model of the controller rules.
module tb_pipe_exec_ctrl;

  localparam int NS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_mode, i_run, i_step, i_halt_id, i_ld_use, i_branch_taken;
  logic [NS-1:0] o_stage_en, o_flush;
  logic          o_busy, o_done;
  logic [1:0]    o_state;
  logic [31:0]   o_cycles;
  logic [NS-1:0] s_stage_en, s_flush;
  logic          s_busy, s_done;
  logic [1:0]    s_state;
  logic [3:0]    s_cycles;

  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 run, 2 drain, 3 done
  int     m_st;
  int     m_left;
  longint m_cyc;

  always #5 clk = ~clk;

  pipe_exec_ctrl #(.NSTAGES(NS), .CBITS(32)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_run(i_run), .i_step(i_step),
    .i_halt_id(i_halt_id), .i_ld_use(i_ld_use), .i_branch_taken(i_branch_taken),
    .o_stage_en(o_stage_en), .o_flush(o_flush), .o_busy(o_busy),
    .o_done(o_done), .o_state(o_state), .o_cycles(o_cycles)
  );

  pipe_exec_ctrl #(.NSTAGES(NS), .CBITS(4)) dut_sat (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_run(i_run), .i_step(i_step),
    .i_halt_id(i_halt_id), .i_ld_use(i_ld_use), .i_branch_taken(i_branch_taken),
    .o_stage_en(s_stage_en), .o_flush(s_flush), .o_busy(s_busy),
    .o_done(s_done), .o_state(s_state), .o_cycles(s_cycles)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_adv();
    return (m_st == 1 || m_st == 2) && (i_mode == 1'b0 || i_step == 1'b1);
  endfunction

  // Compare every output against the model for the current inputs
  task automatic chk_now();
    int     e_en, e_fl, e_st;
    longint e_cyc;
    int     full;
    @(negedge clk);
    full = (1 << NS) - 1;
    e_en = 0; e_fl = 0;
    e_st = m_st; e_cyc = m_cyc;
    if (!rst) begin
      e_st = 0; e_cyc = 0;
    end else if (model_adv()) begin
      if (m_st == 2) begin
        e_en = full - 1; e_fl = 2;
      end else if (i_ld_use) begin
        e_en = full - 3; e_fl = 4;
      end else if (i_halt_id) begin
        e_en = full - 1; e_fl = 2;
      end else if (i_branch_taken) begin
        e_en = full; e_fl = 2;
      end else begin
        e_en = full;
      end
    end
    check("stage_en", 64'(o_stage_en), 64'(e_en));
    check("flush", 64'(o_flush), 64'(e_fl));
    check("state", 64'(o_state), 64'(e_st));
    check("busy", 64'(o_busy), 64'(e_st == 1 || e_st == 2));
    check("done", 64'(o_done), 64'(e_st == 3));
    check("cycles", 64'(o_cycles), 64'(e_cyc));
    check("sat_cycles", 64'(s_cycles), 64'((e_cyc > 15) ? 15 : e_cyc));
    check("sat_stage_en", 64'(s_stage_en), 64'(e_en));
    $display("t=%0t st=%0d en=%b fl=%b cyc=%0d run=%b step=%b mode=%b halt=%b ld=%b br=%b rst=%b",
             $time, o_state, o_stage_en, o_flush, o_cycles, i_run, i_step, i_mode,
             i_halt_id, i_ld_use, i_branch_taken, rst);
  endtask

  task automatic adv_edge();
    bit a;
    a = model_adv();
    if (!rst) begin
      m_st = 0; m_left = 0; m_cyc = 0;
    end else if ((m_st == 0 || m_st == 3) && i_run) begin
      m_st = 1; m_cyc = 0;
    end else if (a) begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (m_st == 1 && !i_ld_use && i_halt_id) begin
        m_st = 2; m_left = NS - 3;
      end else if (m_st == 2) begin
        m_left--;
        if (m_left == 0) m_st = 3;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    chk_now();
    adv_edge();
  endtask

  task automatic clear_in();
    i_run = 0; i_step = 0; i_halt_id = 0; i_ld_use = 0; i_branch_taken = 0;
  endtask

  initial begin
    m_st = 0; m_left = 0; m_cyc = 0;
    rst = 0; i_mode = 0;
    clear_in();
    tick();
    tick();
    rst = 1;
    tick();

    // Continuous run, halt on the sixth advance
    i_run = 1; tick(); i_run = 0;
    for (int k = 0; k < 5; k++) begin
      chk_now();
      check("run_en_all", 64'(o_stage_en), 64'h1F);
      adv_edge();
    end
    i_halt_id = 1; tick(); i_halt_id = 0;
    tick(); tick();
    chk_now();
    check("halt_done", 64'(o_done), 64'd1);
    check("halt_cycles", 64'(o_cycles), 64'd8);
    adv_edge();

    // Load-use stall with a simultaneous halt
    i_run = 1; tick(); i_run = 0;
    i_ld_use = 1; i_halt_id = 1;
    chk_now();
    check("lduse_en", 64'(o_stage_en), 64'b11100);
    check("lduse_flush", 64'(o_flush), 64'b00100);
    adv_edge();
    i_ld_use = 0; i_halt_id = 0;
    chk_now();
    check("lduse_state_run", 64'(o_state), 64'd1);
    check("lduse_recover_en", 64'(o_stage_en), 64'b11111);
    adv_edge();

    // Branch, then branch together with halt
    i_branch_taken = 1;
    chk_now();
    check("br_en", 64'(o_stage_en), 64'b11111);
    check("br_flush", 64'(o_flush), 64'b00010);
    adv_edge();
    i_halt_id = 1;
    chk_now();
    check("brhalt_en", 64'(o_stage_en), 64'b11110);
    check("brhalt_flush", 64'(o_flush), 64'b00010);
    adv_edge();
    clear_in();
    check("brhalt_drain", 64'(o_state), 64'd2);

    // Reset while draining
    rst = 0;
    #1;
    check("rst_state", 64'(o_state), 64'd0);
    check("rst_cycles", 64'(o_cycles), 64'd0);
    check("rst_busy_done", 64'({o_busy, o_done}), 64'd0);
    check("rst_en_flush", 64'({o_stage_en, o_flush}), 64'd0);
    tick();
    rst = 1;
    i_run = 1; tick(); i_run = 0;
    check("restart_state", 64'(o_state), 64'd1);
    check("restart_cycles", 64'(o_cycles), 64'd0);

    // Step mode from IDLE: nothing moves without a step pulse
    rst = 0; tick(); rst = 1;
    i_mode = 1;
    i_run = 1; tick(); i_run = 0;
    for (int k = 0; k < 10; k++) begin
      chk_now();
      check("step_idle_en", 64'(o_stage_en), 64'd0);
      check("step_idle_cyc", 64'(o_cycles), 64'd0);
      adv_edge();
    end
    for (int k = 0; k < 3; k++) begin
      i_step = 1; tick(); i_step = 0; tick();
    end
    check("step_cycles", 64'(o_cycles), 64'd3);

    // Saturation of the narrow counter
    i_mode = 0;
    for (int k = 0; k < 20; k++) tick();
    check("sat_stop_15", 64'(s_cycles), 64'd15);
    check("wide_cycles", 64'(o_cycles), 64'd23);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst            = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 15) == 0) i_mode = ~i_mode;
      i_run          = ($urandom_range(0, 7) == 0);
      i_step         = ($urandom_range(0, 1) == 0);
      i_halt_id      = ($urandom_range(0, 9) == 0);
      i_ld_use       = ($urandom_range(0, 5) == 0);
      i_branch_taken = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
